// File: rtl/echo_responder_if.sv
// Method-style FIFO handshake bundle: the responder calls first/deq on the
// request FIFO and enq on the indication FIFO.
interface echo_responder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_first;
    logic             in_first__RDY;
    logic             in_deq__RDY;
    logic             in_deq__ENA;
    logic             out_enq__RDY;
    logic             out_enq__ENA;
    logic [WIDTH-1:0] out_enq_v;

    // Valid/ready semantics: an __ENA may only be high in a cycle where its
    // matching __RDY is high; the method takes effect on that CLK rising edge.
    modport master (
        input  in_first, in_first__RDY, in_deq__RDY, out_enq__RDY,
        output in_deq__ENA, out_enq__ENA, out_enq_v
    );

    modport slave (
        output in_first, in_first__RDY, in_deq__RDY, out_enq__RDY,
        input  in_deq__ENA, out_enq__ENA, out_enq_v
    );
endinterface

// File: rtl/echo_responder.sv
// Expands each request word {N, P} into N reply words {seq, P}, seq = 0..N-1,
// with zero-bubble hand-off between consecutive bursts.
module echo_responder #(
    parameter int WIDTH      = 32,
    parameter int CNT_BITS   = 8,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    echo_responder_if.master      bus,
    output logic                  busy,
    output logic [STAT_WIDTH-1:0] served,
    output logic [STAT_WIDTH-1:0] dropped,
    output logic                  dbg_state
);
    localparam int PW = WIDTH - CNT_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [CNT_BITS-1:0]   seq_q, seq_d;
    logic [PW-1:0]         payload_q, payload_d;
    logic [STAT_WIDTH-1:0] served_q, served_d;
    logic [STAT_WIDTH-1:0] dropped_q, dropped_d;

    logic                  fire;
    logic                  last_fire;
    logic                  take;
    logic [CNT_BITS-1:0]   cnt_m1;
    logic [CNT_BITS-1:0]   req_n;
    logic [PW-1:0]         req_p;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            seq_q     <= '0;
            payload_q <= '0;
            served_q  <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seq_q     <= seq_d;
            payload_q <= payload_d;
            served_q  <= served_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        payload_d = payload_q;
        served_d  = served_q;
        dropped_d = dropped_q;

        cnt_m1 = cnt_q - CNT_BITS'(1);
        req_n  = bus.in_first[WIDTH-1 -: CNT_BITS];
        req_p  = bus.in_first[PW-1:0];

        // nRST gating keeps both ENAs low during the reset cycle itself.
        fire      = nRST && (state_q == EMIT) && bus.out_enq__RDY;
        last_fire = fire && (seq_q == cnt_m1);
        take      = nRST && bus.in_first__RDY && bus.in_deq__RDY &&
                    ((state_q == IDLE) || last_fire);

        case (state_q)
            IDLE: ;
            EMIT: begin
                if (fire) begin
                    seq_d = seq_q + CNT_BITS'(1);
                    if (last_fire) begin
                        served_d = served_q + STAT_WIDTH'(1);
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A take overrides the end-of-burst return to IDLE, giving back-to-back bursts.
        if (take) begin
            cnt_d     = req_n;
            payload_d = req_p;
            seq_d     = '0;
            if (req_n == '0) begin
                dropped_d = dropped_q + STAT_WIDTH'(1);
                state_d   = IDLE;
            end else begin
                state_d   = EMIT;
            end
        end
    end

    assign bus.in_deq__ENA  = take;
    assign bus.out_enq__ENA = fire;
    assign bus.out_enq_v    = {seq_q, payload_q};
    assign busy             = (state_q == EMIT);
    assign served           = served_q;
    assign dropped          = dropped_q;
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_echo_responder.sv
// Bench for echo_responder: directed vector table, hand-written multi-cycle
// sequences, and a randomized run against a request-queue reference model.
module tb_echo_responder;
    logic        clk;
    logic        nrst;
    logic        busy;
    logic [15:0] served;
    logic [15:0] dropped;
    logic        dbg_state;

    int errors = 0;
    int checks = 0;

    echo_responder_if #(.WIDTH(32)) bus ();

    echo_responder #(.WIDTH(32), .CNT_BITS(8), .STAT_WIDTH(16)) dut (
        .CLK       (clk),
        .nRST      (nrst),
        .bus       (bus),
        .busy      (busy),
        .served    (served),
        .dropped   (dropped),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs just after the edge, then let combinational outputs settle.
    task automatic drive(input logic [31:0] first, input logic frdy, input logic drdy, input logic erdy);
        bus.in_first      = first;
        bus.in_first__RDY = frdy;
        bus.in_deq__RDY   = drdy;
        bus.out_enq__RDY  = erdy;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] first;
        logic        frdy, drdy, erdy;
        logic        exp_deq, exp_enq, exp_busy, chk_v;
        logic [31:0] exp_v;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic [31:0] first, input logic frdy, input logic drdy,
                                input logic erdy, input logic exp_deq, input logic exp_enq,
                                input logic exp_busy, input logic chk_v, input logic [31:0] exp_v);
        vec_t v;
        v.first = first; v.frdy = frdy; v.drdy = drdy; v.erdy = erdy;
        v.exp_deq = exp_deq; v.exp_enq = exp_enq; v.exp_busy = exp_busy;
        v.chk_v = chk_v; v.exp_v = exp_v;
        return v;
    endfunction

    // ---------------- reference model state ----------------
    logic [31:0] up_q[$];
    logic [31:0] exp_q[$];
    int exp_served;
    int exp_dropped;

    initial begin
        logic [31:0] w;
        logic [7:0]  n;
        int cyc;

        bus.in_first = 32'h0; bus.in_first__RDY = 1'b0;
        bus.in_deq__RDY = 1'b0; bus.out_enq__RDY = 1'b0;

        // Reset with both sides offering: no ENA may appear.
        nrst = 1'b0;
        drive(32'h0312_3456, 1'b1, 1'b1, 1'b1);
        check("reset_deq_ena", bus.in_deq__ENA, 0);
        check("reset_enq_ena", bus.out_enq__ENA, 0);
        tick();
        tick();
        nrst = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        check("reset_busy", busy, 0);
        check("reset_served", served, 0);
        check("reset_dropped", dropped, 0);
        check("reset_v", bus.out_enq_v, 0);

        // Single request, zero count, backpressure, deq-not-ready.
        vecs[0]  = mk(32'h0300_ABCD, 1, 1, 1, 1, 0, 0, 0, 32'h0);
        vecs[1]  = mk(32'h0,         0, 1, 1, 0, 1, 1, 1, 32'h0000_ABCD);
        vecs[2]  = mk(32'h0,         0, 1, 1, 0, 1, 1, 1, 32'h0100_ABCD);
        vecs[3]  = mk(32'h0,         0, 1, 1, 0, 1, 1, 1, 32'h0200_ABCD);
        vecs[4]  = mk(32'h0,         0, 1, 1, 0, 0, 0, 0, 32'h0);
        vecs[5]  = mk(32'h0012_3456, 1, 1, 1, 1, 0, 0, 0, 32'h0);
        vecs[6]  = mk(32'h0,         0, 1, 1, 0, 0, 0, 0, 32'h0);
        vecs[7]  = mk(32'h0200_0011, 1, 1, 0, 1, 0, 0, 0, 32'h0);
        vecs[8]  = mk(32'h0,         0, 1, 0, 0, 0, 1, 1, 32'h0000_0011);
        vecs[9]  = mk(32'h7777_7777, 0, 1, 0, 0, 0, 1, 1, 32'h0000_0011);
        vecs[10] = mk(32'h0,         0, 1, 0, 0, 0, 1, 1, 32'h0000_0011);
        vecs[11] = mk(32'h0,         0, 1, 0, 0, 0, 1, 1, 32'h0000_0011);
        vecs[12] = mk(32'h0,         0, 1, 1, 0, 1, 1, 1, 32'h0000_0011);
        vecs[13] = mk(32'h0,         0, 1, 1, 0, 1, 1, 1, 32'h0100_0011);
        vecs[14] = mk(32'h0,         0, 1, 1, 0, 0, 0, 0, 32'h0);
        vecs[15] = mk(32'h0500_0000, 1, 0, 1, 0, 0, 0, 0, 32'h0);
        vecs[16] = mk(32'h0,         0, 1, 1, 0, 0, 0, 0, 32'h0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].first, vecs[i].frdy, vecs[i].drdy, vecs[i].erdy);
            check($sformatf("vec%0d_deq_ena", i), bus.in_deq__ENA, vecs[i].exp_deq);
            check($sformatf("vec%0d_enq_ena", i), bus.out_enq__ENA, vecs[i].exp_enq);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            if (vecs[i].chk_v) check($sformatf("vec%0d_v", i), bus.out_enq_v, vecs[i].exp_v);
            tick();
        end
        check("table_served", served, 2);
        check("table_dropped", dropped, 1);

        // Back-to-back: second dequeue coincides with the single AA reply.
        drive(32'h0100_00AA, 1, 1, 1);
        check("b2b_deq_aa", bus.in_deq__ENA, 1);
        tick();
        drive(32'h0200_00BB, 1, 1, 1);
        check("b2b_deq_bb", bus.in_deq__ENA, 1);
        check("b2b_enq_aa", bus.out_enq__ENA, 1);
        check("b2b_v_aa", bus.out_enq_v, 32'h0000_00AA);
        tick();
        drive(32'h0, 0, 1, 1);
        check("b2b_enq_bb0", bus.out_enq__ENA, 1);
        check("b2b_v_bb0", bus.out_enq_v, 32'h0000_00BB);
        tick();
        drive(32'h0, 0, 1, 1);
        check("b2b_enq_bb1", bus.out_enq__ENA, 1);
        check("b2b_v_bb1", bus.out_enq_v, 32'h0100_00BB);
        tick();
        drive(32'h0, 0, 1, 1);
        check("b2b_busy_end", busy, 0);
        check("b2b_served", served, 4);

        // Max burst of 255.
        drive(32'hFF00_0001, 1, 1, 1);
        check("max_deq", bus.in_deq__ENA, 1);
        tick();
        for (int i = 0; i < 255; i++) begin
            logic [7:0] s;
            s = 8'(i);
            drive(32'h0, 0, 1, 1);
            check($sformatf("max_enq_%0d", i), bus.out_enq__ENA, 1);
            check($sformatf("max_v_%0d", i), bus.out_enq_v, {s, 24'h00_0001});
            tick();
        end
        drive(32'h0, 0, 1, 1);
        check("max_idle_busy", busy, 0);
        check("max_idle_enq", bus.out_enq__ENA, 0);
        check("max_idle_deq", bus.in_deq__ENA, 0);
        check("max_served", served, 5);

        // Reset mid-burst after 2 of 5 replies.
        drive(32'h0500_0077, 1, 1, 1);
        check("mid_deq", bus.in_deq__ENA, 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(32'h0, 0, 1, 1);
            check($sformatf("mid_enq_%0d", i), bus.out_enq__ENA, 1);
            tick();
        end
        nrst = 1'b0;
        drive(32'h0300_0001, 1, 1, 1);
        check("mid_rst_deq", bus.in_deq__ENA, 0);
        check("mid_rst_enq", bus.out_enq__ENA, 0);
        tick();
        nrst = 1'b1;
        drive(32'h0, 0, 1, 1);
        check("mid_after_busy", busy, 0);
        check("mid_after_v", bus.out_enq_v, 0);
        check("mid_after_served", served, 0);
        check("mid_after_dropped", dropped, 0);
        check("mid_after_enq", bus.out_enq__ENA, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(32'h0, 0, 1, 1);
            check($sformatf("mid_quiet_%0d", i), bus.out_enq__ENA | bus.in_deq__ENA, 0);
        end
        tick();

        // Randomized run against a request/reply queue model.
        exp_served = 0;
        exp_dropped = 0;
        for (int i = 0; i < 150; i++) begin
            n = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
            up_q.push_back({n, 24'($urandom)});
        end
        cyc = 0;
        while ((up_q.size() > 0 || exp_q.size() > 0) && cyc < 5000) begin
            logic frdy, drdy, erdy;
            frdy = (up_q.size() > 0) && ($urandom_range(0, 3) != 0);
            drdy = ($urandom_range(0, 4) != 0);
            erdy = ($urandom_range(0, 2) != 0);
            drive(frdy ? up_q[0] : $urandom, frdy, drdy, erdy);
            if (bus.out_enq__ENA) begin
                checks++;
                if (!erdy) begin
                    errors++;
                    $display("FAIL rnd_enq_without_rdy: cycle %0d", cyc);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_extra_reply: got %h expected none", bus.out_enq_v);
                end else begin
                    check("rnd_reply", bus.out_enq_v, exp_q.pop_front());
                end
            end
            if (bus.in_deq__ENA) begin
                checks++;
                if (!(frdy && drdy)) begin
                    errors++;
                    $display("FAIL rnd_deq_without_rdy: cycle %0d", cyc);
                end else begin
                    w = up_q.pop_front();
                    n = w[31:24];
                    if (n == 8'd0) exp_dropped++;
                    else exp_served++;
                    for (int s = 0; s < int'(n); s++) exp_q.push_back({8'(s), w[23:0]});
                end
            end
            tick();
            cyc++;
        end
        if (up_q.size() > 0 || exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL rnd_timeout: got %0d pending expected 0", up_q.size() + exp_q.size());
        end
        drive(32'h0, 0, 1, 1);
        check("rnd_busy_end", busy, 0);
        check("rnd_served", served, 32'(exp_served));
        check("rnd_dropped", dropped, 32'(exp_dropped));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
